// File: rtl/ram_arb_pkg.sv
// Shared types for the RAM arbiter: FSM states, RAM size codes and requester ids.
package ram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2,
        ACK     = 2'd3
    } state_t;

    typedef enum logic {
        REQ_FETCH = 1'b0,
        REQ_DATA  = 1'b1
    } req_id_t;

    localparam logic [1:0] SIZE_BYTE = 2'd1;
    localparam logic [1:0] SIZE_HALF = 2'd2;

endpackage

// File: rtl/ram_arb_pick.sv
// Combinational winner select between fetch and data requests.
// RAM_ARB_RR_EN selects round-robin on ties; otherwise data has fixed priority.
module ram_arb_pick
    import ram_arb_pkg::*;
(
    input  logic    f_req,
    input  logic    d_req,
`ifdef RAM_ARB_RR_EN
    input  req_id_t last_grant,
`endif
    output req_id_t win
);

    always_comb begin
        win = REQ_FETCH;
        if (d_req && f_req) begin
`ifdef RAM_ARB_RR_EN
            win = (last_grant == REQ_DATA) ? REQ_FETCH : REQ_DATA;
`else
            win = REQ_DATA;
`endif
        end else if (d_req) begin
            win = REQ_DATA;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Shares the single-port RAM between instruction fetch and load/store data.
// Define RAM_ARB_RR_EN for round-robin tie-breaking instead of data-over-fetch priority.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              I_clk,
    input  logic              I_reset_n,
    input  logic              I_f_req,
    input  logic [ADDR_W-1:0] I_f_addr,
    input  logic [1:0]        I_f_size,
    output logic              O_f_ack,
    output logic [DATA_W-1:0] O_f_data,
    input  logic              I_d_req,
    input  logic              I_d_write,
    input  logic [ADDR_W-1:0] I_d_addr,
    input  logic [1:0]        I_d_size,
    input  logic [DATA_W-1:0] I_d_data,
    output logic              O_d_ack,
    output logic [DATA_W-1:0] O_d_data,
    output logic              O_ram_enable,
    output logic              O_ram_write,
    output logic [1:0]        O_ram_size,
    output logic [ADDR_W-1:0] O_ram_addr,
    output logic [DATA_W-1:0] O_ram_data,
    input  logic [DATA_W-1:0] I_ram_data
);

    state_t  state;
    req_id_t grant_id;
    req_id_t win;
`ifdef RAM_ARB_RR_EN
    req_id_t last_grant;
`endif

    ram_arb_pick u_pick (
        .f_req      (I_f_req),
        .d_req      (I_d_req),
`ifdef RAM_ARB_RR_EN
        .last_grant (last_grant),
`endif
        .win        (win)
    );

    always_ff @(posedge I_clk or negedge I_reset_n) begin
        if (!I_reset_n) begin
            state        <= IDLE;
            grant_id     <= REQ_FETCH;
`ifdef RAM_ARB_RR_EN
            last_grant   <= REQ_FETCH;
`endif
            O_f_ack      <= 1'b0;
            O_f_data     <= '0;
            O_d_ack      <= 1'b0;
            O_d_data     <= '0;
            O_ram_enable <= 1'b0;
            O_ram_write  <= 1'b0;
            O_ram_size   <= '0;
            O_ram_addr   <= '0;
            O_ram_data   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // Command registers load here so the enable cycle sees a stable command.
                    if (I_f_req || I_d_req) begin
                        grant_id     <= win;
`ifdef RAM_ARB_RR_EN
                        last_grant   <= win;
`endif
                        O_ram_enable <= 1'b1;
                        state        <= ACCESS;
                        if (win == REQ_DATA) begin
                            O_ram_addr  <= I_d_addr;
                            O_ram_size  <= I_d_size;
                            O_ram_write <= I_d_write;
                            O_ram_data  <= I_d_data;
                        end else begin
                            O_ram_addr  <= I_f_addr;
                            O_ram_size  <= I_f_size;
                            O_ram_write <= 1'b0;
                        end
                    end
                end
                ACCESS: begin
                    O_ram_enable <= 1'b0;
                    state        <= CAPTURE;
                end
                CAPTURE: begin
                    if (!O_ram_write) begin
                        if (grant_id == REQ_DATA) O_d_data <= I_ram_data;
                        else                      O_f_data <= I_ram_data;
                    end
                    O_d_ack <= (grant_id == REQ_DATA);
                    O_f_ack <= (grant_id == REQ_FETCH);
                    state   <= ACK;
                end
                ACK: begin
                    O_d_ack <= 1'b0;
                    O_f_ack <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single-port byte-addressed RAM between two requesters: instruction fetch (read-only) and load/store data (read/write).
- Selects one request at a time and drives the RAM command for exactly one cycle.
- Absorbs the RAM's one-cycle read latency and returns registered data with a one-cycle ack pulse.
- Sits between the CPU front-end/LSU and the RAM; it is the only master on the RAM command bus.

Parameters:
- ADDR_W, 16, requester and RAM address width.
- DATA_W, 16, data width; must equal 16 (RAM supports 8- or 16-bit accesses).

Ports:
- I_clk  in  1  clock; all state changes on the rising edge.
- I_reset_n  in  1  asynchronous, active-low reset.
- I_f_req  in  1  fetch request; level, held until O_f_ack.
- I_f_addr  in  ADDR_W  fetch byte address.
- I_f_size  in  2  2 = 16-bit; any other value = 8-bit.
- O_f_ack  out  1  one-cycle completion pulse.
- O_f_data  out  DATA_W  fetch read data, valid while O_f_ack is high, then held.
- I_d_req  in  1  data request; level, held until O_d_ack.
- I_d_write  in  1  1 = store, 0 = load.
- I_d_addr  in  ADDR_W  data byte address.
- I_d_size  in  2  as I_f_size.
- I_d_data  in  DATA_W  store data; the low byte is used for 8-bit stores.
- O_d_ack  out  1  one-cycle completion pulse.
- O_d_data  out  DATA_W  load data, valid while O_d_ack is high, then held.
- O_ram_enable  out  1  RAM enable.
- O_ram_write  out  1  RAM write strobe.
- O_ram_size  out  2  RAM size.
- O_ram_addr  out  ADDR_W  RAM address.
- O_ram_data  out  DATA_W  RAM write data.
- I_ram_data  in  DATA_W  RAM read data; valid the cycle after the enable cycle.

Behaviour:
- Registered FSM with states IDLE, ACCESS, CAPTURE, ACK. All outputs are registered.
- Reset: async assertion forces IDLE and clears every output to 0. Any in-flight transaction is dropped with no ack; requesters reissue after reset.
- IDLE:
  - If any request is high, choose a winner, latch its id, addr, size, write and data into the RAM command registers, then go to ACCESS.
  - Otherwise stay in IDLE with O_ram_enable=0.
- ACCESS:
  - O_ram_enable=1 for exactly this cycle, and the command registers stay stable.
  - The fetch path always drives O_ram_write=0.
  - Next state is CAPTURE.
- CAPTURE:
  - O_ram_enable=0.
  - On a read, I_ram_data is registered into the winner's data output at the end of this cycle.
  - On a write, the data outputs are unchanged.
  - Next state is ACK.
- ACK:
  - The winner's ack is 1 for this cycle only; requests are not sampled.
  - Next state is IDLE.
- Latency: a request high in an IDLE cycle (cycle 0) produces its ack in cycle 3. Minimum issue interval is 4 cycles.
- Requester rule: the requester deasserts req on the edge where it sees ack. If req is still high in the following IDLE cycle, it is a new transaction.
- Requests raised while the arbiter is busy wait; they are evaluated in the next IDLE.
- Arbitration by default: fixed priority, data over fetch.
- Changes to a requester's inputs while it is not granted have no effect.
- Size 2 is forwarded as 2; any other size is forwarded unchanged. The RAM zeroes the upper byte for 8-bit reads, and the arbiter passes this through.
- Address is forwarded unmodified; the RAM uses only bits [11:0].
- O_ram_addr, O_ram_size and O_ram_data hold their last values when idle. Only O_ram_enable is cleared.

Optional Feature:
- Macro: RAM_ARB_RR_EN.
- Defined:
  - Round-robin arbitration using a last_grant flop, reset value "fetch".
  - When both requesters are pending in IDLE, the one not granted last wins.
  - last_grant updates on every grant.
  - Worst-case wait is one transaction.
- Undefined: fixed data-over-fetch priority; last_grant logic is absent.

Decomposition:
- Package ram_arb_pkg:
  - State encoding localparams: IDLE=0, ACCESS=1, CAPTURE=2, ACK=3.
  - Size codes: SIZE_BYTE=1, SIZE_HALF=2.
  - Requester ids: REQ_FETCH=0, REQ_DATA=1.
- Sub-module ram_arb_pick: combinational winner select from the two reqs plus last_grant. It contains the RAM_ARB_RR_EN variant, so the FSM is identical in both builds.

Test Plan:
- Data store then load:
  - Stimulus: store addr 0x0010, size 2, data 0xBEEF; then load addr 0x0010, size 2.
  - Response: O_ram_enable high exactly one cycle each; O_d_ack at cycle 3 each; O_d_data=0xBEEF.
- Byte fetch: fetch addr 0x0011, size 1 after the store above → O_f_data=0x00BE, ack at cycle 3.
- Simultaneous requests: both high in the same IDLE cycle.
  - Default build: data is acked at cycle 3, fetch at cycle 7.
  - RR build, from reset: data first; with both held and reissued, the next tie grants fetch.
- Busy arrival: fetch is raised while a data transaction is in ACCESS → fetch is not seen on the RAM until the next IDLE; its ack comes 4 cycles after O_d_ack.
- Reset mid-operation: I_reset_n low during CAPTURE → all outputs 0 immediately, no ack; after release, an IDLE cycle is followed by normal service.
- Starvation check in the default build: data held continuously high with back-to-back reissue → fetch is never granted. The RR build grants fetch every second transaction.
